// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the oversampled UART receiver.
//               Holds the receiver state encoding, default frame constants and
//               the derived mid-bit sample indices.
//               Optional feature macro: UART_RX_PARITY_EN (adds the PARITY
//               state to the encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;
    localparam int unsigned DATA_BITS_DEFAULT  = 8;

    // Three samples straddle the centre of each bit period.
    localparam int unsigned SAMPLE_LO  = OVERSAMPLE_DEFAULT / 2 - 1;
    localparam int unsigned SAMPLE_MID = OVERSAMPLE_DEFAULT / 2;
    localparam int unsigned SAMPLE_HI  = OVERSAMPLE_DEFAULT / 2 + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_t;

    // Sample indices for an arbitrary oversample ratio.
    function automatic int unsigned sample_lo(input int unsigned os);
        return os / 2 - 1;
    endfunction

    function automatic int unsigned sample_mid(input int unsigned os);
        return os / 2;
    endfunction

    function automatic int unsigned sample_hi(input int unsigned os);
        return os / 2 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_oversampled_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled_if
// Description : Byte output channel of the UART receiver (valid/ready with
//               per-byte status).
//   master : receiver side - drives data, valid, frameErr, parityErr, overrun;
//            samples ready.
//   slave  : consumer side - samples the byte and status; drives ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_oversampled_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frameErr;
    logic                 parityErr;
    logic                 overrun;

    modport master (
        output data,
        output valid,
        output frameErr,
        output parityErr,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frameErr,
        input  parityErr,
        input  overrun,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Multi-flop synchroniser for the asynchronous rx pad. Flops
//               reset to 1 so an idle line is not mistaken for a start bit
//               while the chain refills after reset.
//   clk       in  system clock
//   nReset    in  asynchronous active-low reset
//   rx        in  asynchronous serial line
//   rx_synced out rx delayed by SYNC_STAGES clocks
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic nReset,
    input  wire logic rx,
    output logic      rx_synced
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_synced = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : Oversampled UART receiver. Detects the start bit, votes three
//               mid-bit samples per bit and presents each byte on a
//               valid/ready channel with framing, parity and overrun status.
//   clk       in  system clock
//   nReset    in  asynchronous active-low reset
//   rxTick    in  one-clk enable, OVERSAMPLE pulses per bit
//   rx        in  asynchronous serial line, idle high
//   parityOdd in  1 = odd parity, 0 = even (parity builds only)
//   busy      out receiver FSM not idle
//   rx_if     master side of the byte output channel
// Optional feature macro: UART_RX_PARITY_EN - adds a parity bit between the
//   data bits and the stop bit and drives parityErr; otherwise parityOdd is
//   ignored and parityErr stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DATA_BITS_DEFAULT,
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  wire logic               clk,
    input  wire logic               nReset,
    input  wire logic               rxTick,
    input  wire logic               rx,
    input  wire logic               parityOdd,
    output logic                    busy,
    uart_rx_oversampled_if.master   rx_if
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] C_TICK_LO   = TW'(sample_lo(OVERSAMPLE));
    localparam logic [TW-1:0] C_TICK_MID  = TW'(sample_mid(OVERSAMPLE));
    localparam logic [TW-1:0] C_TICK_HI   = TW'(sample_hi(OVERSAMPLE));
    localparam logic [TW-1:0] C_TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] C_BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 w_rx;
    logic                 w_vote;
    logic                 w_complete;
    logic                 w_parity_err;

    rx_state_t            r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s_lo;
    logic                 r_s_mid;
    logic                 r_busy;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .nReset    (nReset),
        .rx        (rx),
        .rx_synced (w_rx)
    );

    // The third sample is taken live, so the vote is valid on the HI tick.
    assign w_vote = (r_s_lo & r_s_mid) | (r_s_lo & w_rx) | (r_s_mid & w_rx);

    // A frame finishes at the centre of the stop bit; the rest of the stop
    // bit is spent in IDLE so a back-to-back start edge is never missed.
    assign w_complete = rxTick && (r_state == ST_STOP) && (r_tick == C_TICK_HI);

`ifdef UART_RX_PARITY_EN
    logic r_par;
    assign w_parity_err = (((^r_shift) ^ r_par) != parityOdd);
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = parityOdd;
    assign w_parity_err        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Receive FSM with tick/bit counters; everything frozen between ticks.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_s_lo  <= 1'b0;
            r_s_mid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (rxTick) begin
            if (r_tick == C_TICK_LO) begin
                r_s_lo <= w_rx;
            end
            if (r_tick == C_TICK_MID) begin
                r_s_mid <= w_rx;
            end

            case (r_state)
                ST_IDLE: begin
                    r_tick <= '0;
                    if (!w_rx) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if ((r_tick == C_TICK_HI) && w_vote) begin
                        // Glitch rather than a real start bit.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_tick  <= '0;
                    end else if (r_tick == C_TICK_LAST) begin
                        r_state <= ST_DATA;
                        r_tick  <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (r_tick == C_TICK_HI) begin
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    end
                    if (r_tick == C_TICK_LAST) begin
                        r_tick <= '0;
                        if (r_bit == C_BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (r_tick == C_TICK_HI) begin
                        r_par <= w_vote;
                    end
                    if (r_tick == C_TICK_LAST) begin
                        r_state <= ST_STOP;
                        r_tick  <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (r_tick == C_TICK_HI) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_tick  <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_tick  <= '0;
                end
            endcase
        end
    end

    assign busy = r_busy;

    // ------------------------------------------------------------------
    // Output register and valid/ready handshake (runs every clk).
    // A completed frame replaces the held byte only if the slot is empty
    // or is being emptied in the same cycle; otherwise it is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rx_if.data      <= '0;
            rx_if.valid     <= 1'b0;
            rx_if.frameErr  <= 1'b0;
            rx_if.parityErr <= 1'b0;
            rx_if.overrun   <= 1'b0;
        end else if (w_complete) begin
            if (!rx_if.valid || rx_if.ready) begin
                rx_if.data      <= r_shift;
                rx_if.valid     <= 1'b1;
                rx_if.frameErr  <= ~w_vote;
                rx_if.parityErr <= w_parity_err;
                rx_if.overrun   <= 1'b0;
            end else begin
                rx_if.overrun <= 1'b1;
            end
        end else if (rx_if.valid && rx_if.ready) begin
            rx_if.valid   <= 1'b0;
            rx_if.overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_oversampled
// Description : Directed self-checking bench for uart_rx_oversampled. rxTick
//               pulses every 4 clks, 16 ticks per bit. Bits are driven just
//               after a tick so the synchroniser settles before the next one.
//               Parity checks are included when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       rxTick = 1'b0;
    logic       rx = 1'b1;
    logic       parityOdd = 1'b0;
    logic       busy;
    logic [1:0] tick_div = 2'd0;

    int n_asserts = 0;
    int n_fail    = 0;

    // Transfer monitor (valid && ready seen by the consumer)
    int         cap_cnt = 0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_fe = 1'b0;
    logic       cap_pe = 1'b0;
    logic       busy_mid;
    logic       busy_end;
    int         cnt_before;

    uart_rx_oversampled_if #(.DATA_BITS(8)) ifc ();

    uart_rx_oversampled #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .nReset    (nReset),
        .rxTick    (rxTick),
        .rx        (rx),
        .parityOdd (parityOdd),
        .busy      (busy),
        .rx_if     (ifc.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_div <= tick_div + 2'd1;
        rxTick   <= (tick_div == 2'd2);
    end

    always @(negedge clk) begin
        if (nReset && ifc.valid && ifc.ready) begin
            cap_cnt  = cap_cnt + 1;
            cap_data = ifc.data;
            cap_fe   = ifc.frameErr;
            cap_pe   = ifc.parityErr;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (!rxTick);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    // Hold one bit for 16 ticks; optionally invert it for the single tick
    // slot goff (slot 9 lands on the middle sample).
    task automatic drive_bit(input logic v, input int goff);
        for (int t = 0; t < 16; t++) begin
            rx = (t == goff) ? ~v : v;
            wait_tick();
        end
    endtask

    // Full frame; gbit selects the bit to glitch (0 = start, 1..8 = data).
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic par_v, input int gbit);
        drive_bit(1'b0, (gbit == 0) ? 9 : -1);
        for (int b = 0; b < 8; b++) begin
            drive_bit(d[b], (gbit == b + 1) ? 9 : -1);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit(par_v, -1);
`else
        if (par_v) begin end
`endif
        rx = stop_v;
        wait_ticks(8);
        busy_mid = busy;
        wait_ticks(8);
        busy_end = busy;
        rx = 1'b1;
        wait_ticks(20);
    endtask

    initial begin
        logic [7:0] abort_byte;
        ifc.ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 nReset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_valid",   {31'd0, ifc.valid},     32'd0);
        check("rst_busy",    {31'd0, busy},          32'd0);
        check("rst_data",    {24'd0, ifc.data},      32'd0);
        check("rst_overrun", {31'd0, ifc.overrun},   32'd0);
        check("rst_ferr",    {31'd0, ifc.frameErr},  32'd0);
        check("rst_perr",    {31'd0, ifc.parityErr}, 32'd0);

        // 0x55 clean frame, ready high
        cnt_before = cap_cnt;
        send_frame(8'h55, 1'b1, 1'b0, -1);
        check("f55_count",   cap_cnt - cnt_before,   32'd1);
        check("f55_data",    {24'd0, cap_data},      32'h55);
        check("f55_ferr",    {31'd0, cap_fe},        32'd0);
        check("f55_perr",    {31'd0, cap_pe},        32'd0);
        check("f55_overrun", {31'd0, ifc.overrun},   32'd0);
        check("f55_valid",   {31'd0, ifc.valid},     32'd0);
        check("f55_busymid", {31'd0, busy_mid},      32'd1);
        check("f55_busyend", {31'd0, busy_end},      32'd0);

        // False start: 4 ticks low
        cnt_before = cap_cnt;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        check("fs_busy_hi",  {31'd0, busy},          32'd1);
        wait_ticks(16);
        check("fs_busy_lo",  {31'd0, busy},          32'd0);
        check("fs_count",    cap_cnt - cnt_before,   32'd0);
        wait_ticks(10);

        // 0xA3 with middle-sample glitch on data bit 2
        cnt_before = cap_cnt;
        send_frame(8'hA3, 1'b1, 1'b0, 3);
        check("fa3_count",   cap_cnt - cnt_before,   32'd1);
        check("fa3_data",    {24'd0, cap_data},      32'hA3);

        // 0x3C with stop bit 0: delivered with frame error
        cnt_before = cap_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        check("f3c_count",   cap_cnt - cnt_before,   32'd1);
        check("f3c_data",    {24'd0, cap_data},      32'h3C);
        check("f3c_ferr",    {31'd0, cap_fe},        32'd1);

        // Overrun: consumer stalled for two frames
        ifc.ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, -1);
        check("ov1_valid",   {31'd0, ifc.valid},     32'd1);
        check("ov1_data",    {24'd0, ifc.data},      32'h11);
        check("ov1_overrun", {31'd0, ifc.overrun},   32'd0);
        check("ov1_ferr",    {31'd0, ifc.frameErr},  32'd0);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        check("ov2_valid",   {31'd0, ifc.valid},     32'd1);
        check("ov2_data",    {24'd0, ifc.data},      32'h11);
        check("ov2_overrun", {31'd0, ifc.overrun},   32'd1);
        cnt_before = cap_cnt;
        ifc.ready = 1'b1;
        @(posedge clk);
        #1;
        check("ov3_valid",   {31'd0, ifc.valid},     32'd0);
        check("ov3_overrun", {31'd0, ifc.overrun},   32'd0);
        check("ov3_count",   cap_cnt - cnt_before,   32'd1);
        check("ov3_data",    {24'd0, cap_data},      32'h11);

        // Reset during data bit 3 (bit value 1 so the line idles high)
        abort_byte = 8'h0F;
        drive_bit(1'b0, -1);
        for (int b = 0; b < 3; b++) drive_bit(abort_byte[b], -1);
        rx = abort_byte[3];
        wait_ticks(8);
        check("ar_busy_pre", {31'd0, busy},          32'd1);
        nReset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ar_busy",     {31'd0, busy},          32'd0);
        check("ar_valid",    {31'd0, ifc.valid},     32'd0);
        nReset = 1'b1;
        rx = 1'b1;
        wait_ticks(30);
        check("ar_valid2",   {31'd0, ifc.valid},     32'd0);
        cnt_before = cap_cnt;
        send_frame(8'hF0, 1'b1, 1'b0, -1);
        check("ff0_count",   cap_cnt - cnt_before,   32'd1);
        check("ff0_data",    {24'd0, cap_data},      32'hF0);
        check("ff0_ferr",    {31'd0, cap_fe},        32'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity, 0x07 has three ones
        parityOdd = 1'b0;
        cnt_before = cap_cnt;
        send_frame(8'h07, 1'b1, 1'b0, -1);
        check("p0_count",    cap_cnt - cnt_before,   32'd1);
        check("p0_perr",     {31'd0, cap_pe},        32'd1);
        cnt_before = cap_cnt;
        send_frame(8'h07, 1'b1, 1'b1, -1);
        check("p1_count",    cap_cnt - cnt_before,   32'd1);
        check("p1_perr",     {31'd0, cap_pe},        32'd0);
        check("p1_data",     {24'd0, cap_data},      32'h07);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
